ppu_timing_m: RTL and testbench

Parametrised LCD timing generator for the PPU: dot and line counters, the mode 0/1/2/3 state machine, the LY/LYC coincidence flag, and the STAT and VBlank interrupt sources. It sits between the CPU register bus (LCDC/STAT/LY/LYC) and the pixel pipeline, which it drives with per-line and per-frame strobes. Geometry is parametrised, so the same block serves the stock 456×154 timing and shortened timings used by fast simulation benches.

---
 rtl/ppu_timing_m.sv | 191 +++++++++++++++++++
 tb/tb_ppu_timing_m.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_timing_m.sv
// ppu_timing_m: LCD timing generator for the PPU.
//
// Generates the dot and line counters and the mode 0/1/2/3 sequence.
// Also provides the LY/LYC coincidence flag, the STAT and VBlank interrupt
// pulses, and a small CPU-visible register file (LCDC, STAT, LY, LYC).
// Line and frame geometry are parameters.
//
// Ports:
//   clk          system clock, one dot per cycle
//   reset        synchronous, active-high
//   reg_addr     register select: 0 LCDC, 1 STAT, 4 LY, 5 LYC (low nibble of
//                FF40/FF41/FF44/FF45); any other value reads 8'hFF
//   reg_write    write strobe
//   reg_d_wr     write data
//   reg_d_rd     read data, combinational from reg_addr
//   draw_done    end-of-draw from the pixel fetcher (variable-draw build only)
//   dot, ly      current dot within the line / current line
//   mode         0 HBlank, 1 VBlank, 2 OAM scan, 3 draw
//   line_start   dot 0 of a visible line
//   frame_start  dot 0 of line 0
//   vblank_irq   dot 0 of the first VBlank line
//   stat_irq     rising edge of the STAT interrupt line
//
// Build option: define PPU_TIMING_VAR_DRAW_EN to let draw_done end mode 3
// early.
//
// mode          | meaning
// MODE_HBLANK   | 0: horizontal blank, or display disabled
// MODE_VBLANK   | 1: lines VISIBLE_LINES..LINES_PER_FRAME-1
// MODE_OAM      | 2: OAM scan, dots 0..OAM_DOTS-1
// MODE_DRAW     | 3: pixel transfer, up to the mode 3 boundary
module ppu_timing_m #(
  parameter int DOTS_PER_LINE   = 456,
  parameter int LINES_PER_FRAME = 154,
  parameter int VISIBLE_LINES   = 144,
  parameter int OAM_DOTS        = 80,
  parameter int DRAW_DOTS       = 172,
  parameter int DOT_W           = $clog2(DOTS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       reg_addr,
  input  logic             reg_write,
  input  logic [7:0]       reg_d_wr,
  output logic [7:0]       reg_d_rd,
  input  logic             draw_done,
  output logic [DOT_W-1:0] dot,
  output logic [7:0]       ly,
  output logic [1:0]       mode,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_irq,
  output logic             stat_irq
);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } mode_e;

  localparam logic [3:0]       ADDR_LCDC = 4'h0;
  localparam logic [3:0]       ADDR_STAT = 4'h1;
  localparam logic [3:0]       ADDR_LY   = 4'h4;
  localparam logic [3:0]       ADDR_LYC  = 4'h5;
  localparam logic [DOT_W-1:0] DOT_LAST  = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] OAM_END   = DOT_W'(OAM_DOTS);
  localparam logic [7:0]       LY_LAST   = 8'(LINES_PER_FRAME - 1);
  localparam logic [7:0]       LY_VBLANK = 8'(VISIBLE_LINES);

  logic [7:0]       lcdc_q, lcdc_d;
  logic [3:0]       sten_q, sten_d;   // STAT[6:3]
  logic [7:0]       lyc_q, lyc_d;
  logic [DOT_W-1:0] dot_q, dot_d;
  logic [7:0]       ly_q, ly_d;
  logic             line_q, line_d;
  logic [DOT_W-1:0] m3_end;           // first dot after mode 3 on this line
  logic             en, run, coinc, line;
  mode_e            mode_s;

`ifdef PPU_TIMING_VAR_DRAW_EN
  logic [DOT_W-1:0] mode3_end_q, mode3_end_d;
  assign m3_end = mode3_end_q;
`else
  localparam logic [DOT_W-1:0] DRAW_END = DOT_W'(OAM_DOTS + DRAW_DOTS);
  logic draw_done_unused;
  assign draw_done_unused = draw_done;
  assign m3_end = DRAW_END;
`endif

  assign en = lcdc_q[7];

  always_comb begin
    mode_s = MODE_HBLANK;
    if (en) begin
      if (ly_q >= LY_VBLANK)    mode_s = MODE_VBLANK;
      else if (dot_q < OAM_END) mode_s = MODE_OAM;
      else if (dot_q < m3_end)  mode_s = MODE_DRAW;
      else                      mode_s = MODE_HBLANK;
    end
  end

  assign coinc = (ly_q == lyc_q);
  assign line  = en & ((sten_q[0] & (mode_s == MODE_HBLANK)) |
                       (sten_q[1] & (mode_s == MODE_VBLANK)) |
                       (sten_q[2] & (mode_s == MODE_OAM))    |
                       (sten_q[3] & coinc));

  always_comb begin
    lcdc_d = lcdc_q;
    sten_d = sten_q;
    lyc_d  = lyc_q;
    if (reg_write) begin
      case (reg_addr)
        ADDR_LCDC: lcdc_d = reg_d_wr;
        ADDR_STAT: sten_d = reg_d_wr[6:3];
        ADDR_LYC:  lyc_d  = reg_d_wr;
        default:   ;
      endcase
    end

    // Counters advance only while enabled both before and after this edge.
    // Any disable, and the enable edge itself, lands the counters on 0/0.
    run   = lcdc_q[7] & lcdc_d[7];
    dot_d = '0;
    ly_d  = '0;
    if (run) begin
      if (dot_q == DOT_LAST) begin
        ly_d = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + DOT_W'(1);
        ly_d  = ly_q;
      end
    end

    line_d = lcdc_d[7] ? line : 1'b0;

`ifdef PPU_TIMING_VAR_DRAW_EN
    // Default boundary DOT_LAST guarantees at least one HBlank dot per line.
    mode3_end_d = mode3_end_q;
    if (!run || dot_q == DOT_LAST)
      mode3_end_d = DOT_LAST;
    else if (mode_s == MODE_DRAW && draw_done)
      mode3_end_d = dot_q + DOT_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcdc_q <= '0;
      sten_q <= '0;
      lyc_q  <= '0;
      dot_q  <= '0;
      ly_q   <= '0;
      line_q <= 1'b0;
`ifdef PPU_TIMING_VAR_DRAW_EN
      mode3_end_q <= DOT_LAST;
`endif
    end else begin
      lcdc_q <= lcdc_d;
      sten_q <= sten_d;
      lyc_q  <= lyc_d;
      dot_q  <= dot_d;
      ly_q   <= ly_d;
      line_q <= line_d;
`ifdef PPU_TIMING_VAR_DRAW_EN
      mode3_end_q <= mode3_end_d;
`endif
    end
  end

  assign dot         = dot_q;
  assign ly          = ly_q;
  assign mode        = mode_s;
  assign line_start  = en & (dot_q == '0) & (ly_q < LY_VBLANK);
  assign frame_start = en & (dot_q == '0) & (ly_q == 8'd0);
  assign vblank_irq  = en & (dot_q == '0) & (ly_q == LY_VBLANK);
  assign stat_irq    = line & ~line_q;

  always_comb begin
    case (reg_addr)
      ADDR_LCDC: reg_d_rd = lcdc_q;
      ADDR_STAT: reg_d_rd = {1'b1, sten_q, coinc, mode_s};
      ADDR_LY:   reg_d_rd = ly_q;
      ADDR_LYC:  reg_d_rd = lyc_q;
      default:   reg_d_rd = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_ppu_timing_m.sv
module tb_ppu_timing_m;

  localparam int DPL = 456;
  localparam int LPF = 154;
  localparam int VIS = 144;
  localparam int OAM = 80;
  localparam int DRW = 172;
`ifdef PPU_TIMING_VAR_DRAW_EN
  localparam int M3_DEFAULT = DPL - 1;
`else
  localparam int M3_DEFAULT = OAM + DRW;
`endif

  localparam logic [3:0] A_LCDC = 4'h0, A_STAT = 4'h1, A_LY = 4'h4, A_LYC = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] reg_addr;
  logic       reg_write;
  logic [7:0] reg_d_wr;
  logic [7:0] reg_d_rd;
  logic       draw_done;
  logic [8:0] dot;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       line_start, frame_start, vblank_irq, stat_irq;

  ppu_timing_m #(
    .DOTS_PER_LINE(DPL), .LINES_PER_FRAME(LPF), .VISIBLE_LINES(VIS),
    .OAM_DOTS(OAM), .DRAW_DOTS(DRW)
  ) dut (
    .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_write(reg_write),
    .reg_d_wr(reg_d_wr), .reg_d_rd(reg_d_rd), .draw_done(draw_done),
    .dot(dot), .ly(ly), .mode(mode), .line_start(line_start),
    .frame_start(frame_start), .vblank_irq(vblank_irq), .stat_irq(stat_irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                 nm, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: time since enable, plus shadow register contents.
  int         m_t;
  logic [7:0] m_lcdc, m_lyc;
  logic [3:0] m_sten;
  bit         m_line_q;
  int         m_m3end;

  function automatic bit e_en();
    return m_lcdc[7];
  endfunction
  function automatic int e_dot();
    return e_en() ? (m_t % DPL) : 0;
  endfunction
  function automatic int e_ly();
    return e_en() ? ((m_t / DPL) % LPF) : 0;
  endfunction
  function automatic int e_mode();
    if (!e_en())           return 0;
    if (e_ly() >= VIS)     return 1;
    if (e_dot() < OAM)     return 2;
    if (e_dot() < m_m3end) return 3;
    return 0;
  endfunction
  function automatic bit e_coinc();
    return e_ly() == int'(m_lyc);
  endfunction
  function automatic bit e_line();
    int md;
    md = e_mode();
    return e_en() && ((m_sten[0] && md == 0) || (m_sten[1] && md == 1) ||
                      (m_sten[2] && md == 2) || (m_sten[3] && e_coinc()));
  endfunction
  function automatic int e_rd(logic [3:0] a);
    case (a)
      A_LCDC:  return int'(m_lcdc);
      A_STAT:  return 128 + int'(m_sten) * 8 + int'(e_coinc()) * 4 + e_mode();
      A_LY:    return e_ly();
      A_LYC:   return int'(m_lyc);
      default: return 255;
    endcase
  endfunction

  bit p_line, p_en, p_cap;
  int p_dot;
  always @(posedge clk) begin
    if (reset) begin
      m_lcdc = 8'h00; m_sten = 4'h0; m_lyc = 8'h00;
      m_t = 0; m_line_q = 1'b0; m_m3end = M3_DEFAULT;
    end else begin
      p_line = e_line();
      p_en   = e_en();
      p_cap  = (e_mode() == 3) && (draw_done === 1'b1);
      p_dot  = e_dot();
      if (reg_write) begin
        if (reg_addr == A_LCDC) m_lcdc = reg_d_wr;
        if (reg_addr == A_STAT) m_sten = reg_d_wr[6:3];
        if (reg_addr == A_LYC)  m_lyc  = reg_d_wr;
      end
      if (p_en && m_lcdc[7]) m_t++;
      else                   m_t = 0;
      m_line_q = m_lcdc[7] ? p_line : 1'b0;
`ifdef PPU_TIMING_VAR_DRAW_EN
      if (!(p_en && m_lcdc[7]) || e_dot() == 0) m_m3end = DPL - 1;
      else if (p_cap)                          m_m3end = p_dot + 1;
`endif
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dot",         int'(dot),         e_dot());
      chk("ly",          int'(ly),          e_ly());
      chk("mode",        int'(mode),        e_mode());
      chk("line_start",  int'(line_start),  int'(e_en() && e_dot() == 0 && e_ly() < VIS));
      chk("frame_start", int'(frame_start), int'(e_en() && e_dot() == 0 && e_ly() == 0));
      chk("vblank_irq",  int'(vblank_irq),  int'(e_en() && e_dot() == 0 && e_ly() == VIS));
      chk("stat_irq",    int'(stat_irq),    int'(e_line() && !m_line_q));
      chk("reg_d_rd",    int'(reg_d_rd),    e_rd(reg_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    reg_addr = a; reg_d_wr = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, string nm, int exp);
    reg_addr = a;
    #1;
    chk(nm, int'(reg_d_rd), exp);
  endtask

  task automatic go(int l, int d);
    int tgt, n;
    tgt = l * DPL + d;
    n = 0;
    while (m_t < tgt && n < 80000) begin
      tick();
      n++;
    end
    if (m_t != tgt) begin
      tests++; fails++;
      $display("FAIL goto_timeout: reached t=%0d, required %0d", m_t, tgt);
    end
  endtask

  int pulses;

  initial begin
    reset = 1'b1; reg_addr = A_LCDC; reg_write = 1'b0; reg_d_wr = 8'h00; draw_done = 1'b0;
    tick();
    chk_on = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_dot", int'(dot), 0);
    chk("rst_ly", int'(ly), 0);
    chk("rst_mode", int'(mode), 0);
    rd(A_STAT, "rst_stat_rd", 8'h84);
    rd(4'h7, "unmapped_rd", 8'hFF);

    wr(A_LYC, 8'h05);
    wr(A_STAT, 8'h40);
    rd(A_STAT, "stat_rd_disabled", 8'hC0);

    wr(A_LCDC, 8'h81);
    chk("en_frame_start", int'(frame_start), 1);
    chk("en_line_start", int'(line_start), 1);
    chk("en_dot", int'(dot), 0);
    chk("en_mode", int'(mode), 2);
    go(0, 80);  chk("mode_dot80", int'(mode), 3);
    go(0, 252); chk("mode_dot252", int'(mode), 0);
    go(0, 455); chk("mode_dot455", int'(mode), 0);
    tick();
    chk("wrap_ly", int'(ly), 1);
    chk("wrap_dot", int'(dot), 0);

    wr(A_LY, 8'h33);
    rd(A_LY, "ly_write_ignored", 1);

    go(5, 0);
    chk("lyc_stat_irq", int'(stat_irq), 1);
    rd(A_STAT, "stat_rd_mode2_coinc", 8'hC6);
    tick();
    chk("lyc_stat_irq_once", int'(stat_irq), 0);

    go(6, 100);
    wr(A_STAT, 8'h28);
    go(6, 252); chk("hblank_irq_l6", int'(stat_irq), 1);
    tick();     chk("hblank_irq_l6_pulse", int'(stat_irq), 0);
    go(7, 0);   chk("no_irq_dot0_l7", int'(stat_irq), 0);
    go(7, 252); chk("hblank_irq_l7", int'(stat_irq), 1);

    go(20, 10);
    wr(A_LCDC, 8'h01);
    chk("dis_ly", int'(ly), 0);
    chk("dis_dot", int'(dot), 0);
    chk("dis_mode", int'(mode), 0);
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      pulses += int'(line_start) + int'(frame_start) + int'(vblank_irq) + int'(stat_irq);
    end
    chk("dis_pulses", pulses, 0);
    rd(A_STAT, "dis_stat_rd", 8'hA8);
    wr(A_LYC, 8'h00);
    rd(A_STAT, "dis_coinc_lyc0", 8'hAC);

    wr(A_LCDC, 8'h81);
    chk("reen_frame_start", int'(frame_start), 1);
    chk("reen_mode", int'(mode), 2);
    chk("reen_oam_irq", int'(stat_irq), 1);

    go(144, 0);
    chk("vbl_mode", int'(mode), 1);
    chk("vbl_irq", int'(vblank_irq), 1);
    tick();
    chk("vbl_irq_pulse", int'(vblank_irq), 0);
    go(153, 455);
    chk("pre_frame_start", int'(frame_start), 0);
    tick();
    chk("frame2_start", int'(frame_start), 1);
    chk("frame2_ly", int'(ly), 0);

    reset = 1'b1;
    reg_addr = A_LCDC; reg_d_wr = 8'h91; reg_write = 1'b1;
    tick();
    reset = 1'b0; reg_write = 1'b0;
    rd(A_LCDC, "reset_beats_write", 8'h00);
    chk("reset_mode", int'(mode), 0);

`ifdef PPU_TIMING_VAR_DRAW_EN
    wr(A_LCDC, 8'h80);
    go(0, 200);
    chk("vd_mode_dot200", int'(mode), 3);
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("vd_mode_dot201", int'(mode), 0);
    go(1, 454); chk("vd_forced_dot454", int'(mode), 3);
    tick();     chk("vd_forced_dot455", int'(mode), 0);
`endif

    tick();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
